spi_rx_scanner: RTL

- Parametrised read-only SPI master for serial ADC/sensor Pmods (ALS-class parts: 16-bit frame, 8 significant bits).
- Successor to the single-channel light-sensor reader. Adds configurable divider, frame width, data field position, multiple chip-selects scanned round-robin, an enable/busy/valid handshake, and a defined inter-frame gap.
- Sits between the Pmod pins and user logic (LED/display drivers).

---
 rtl/spi_rx_pkg.sv | 21 ++
 rtl/spi_tick_gen.sv | 33 +++
 rtl/spi_rx_scanner.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the read-only SPI scanner.
// ALS-class default frame: 16 clocks, 8-bit field starting at bit 4.
package spi_rx_pkg;

    localparam int ALS_FRAME_W  = 16;
    localparam int ALS_DATA_W   = 8;
    localparam int ALS_DATA_LSB = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_e;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-SCLK tick generator: counts 0..DIV-1, pulses tick_o on DIV-1, then wraps.
// One-cycle pulse every DIV clocks; clr_i holds the count at 0 (no backpressure).
module spi_tick_gen #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = $clog2(DIV);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_rx_scanner.sv
// Round-robin read-only SPI master; one field per frame, (2+2*FRAME_W+GAP_TICKS)*DIV clocks per frame.
// No backpressure: valid is a one-cycle pulse. SPI_RX_THRESH_EN adds thresh/above compare.
module spi_rx_scanner
    import spi_rx_pkg::*;
#(
    parameter int DIV       = 50,
    parameter int FRAME_W   = ALS_FRAME_W,
    parameter int DATA_W    = ALS_DATA_W,
    parameter int DATA_LSB  = ALS_DATA_LSB,
    parameter int NUM_CH    = 1,
    parameter int GAP_TICKS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      sdo,
`ifdef SPI_RX_THRESH_EN
    input  logic [DATA_W-1:0]         thresh,
    output logic [NUM_CH-1:0]         above,
`endif
    output logic                      sclk,
    output logic [NUM_CH-1:0]         cs_n,
    output logic                      busy,
    output logic [DATA_W-1:0]         data,
    output logic [ch_w(NUM_CH)-1:0]   ch,
    output logic                      valid
);

    localparam int CH_W = ch_w(NUM_CH);
    localparam int SR_W = DATA_LSB + DATA_W;
    localparam int BW   = $clog2(FRAME_W);
    localparam int GW   = (GAP_TICKS <= 1) ? 1 : $clog2(GAP_TICKS);

    state_e            state_q, state_d;
    logic              sclk_q, sclk_d;
    logic [NUM_CH-1:0] cs_n_q, cs_n_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              valid_q, valid_d;
    logic              tick;
    logic [DATA_W-1:0] field;
    logic [NUM_CH-1:0] cs_sel;
    logic [CH_W-1:0]   ptr_nxt;

    spi_tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == IDLE),
        .tick_o (tick)
    );

    // Only the low SR_W frame bits matter; earlier bits fall off the top.
    assign field   = sr_q[SR_W-1 -: DATA_W];
    assign cs_sel  = ~(NUM_CH'(1) << ptr_q);
    assign ptr_nxt = (ptr_q == CH_W'(NUM_CH - 1)) ? '0 : ptr_q + 1'b1;

    always_comb begin
        state_d = state_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sr_d    = sr_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = SETUP;
                    cs_n_d  = cs_sel;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                    bit_d   = '0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        sr_d  = (sr_q << 1) | SR_W'(sdo);
                        bit_d = bit_q + 1'b1;
                        if (bit_q == BW'(FRAME_W - 1)) begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    cs_n_d  = '1;
                    data_d  = field;
                    ch_d    = ptr_q;
                    valid_d = 1'b1;
                    ptr_d   = ptr_nxt;
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_q == GW'(GAP_TICKS - 1)) begin
                        gap_d = '0;
                        if (en) begin
                            state_d = SETUP;
                            cs_n_d  = cs_sel;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sclk_q  <= 1'b1;
            cs_n_q  <= '1;
            bit_q   <= '0;
            gap_q   <= '0;
            sr_q    <= '0;
            ptr_q   <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            sr_q    <= sr_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
        end
    end

`ifdef SPI_RX_THRESH_EN
    logic [NUM_CH-1:0] above_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            above_q <= '0;
        end else if (state_q == HOLD && tick) begin
            above_q[ptr_q] <= (field >= thresh);
        end
    end

    assign above = above_q;
`endif

    assign sclk  = sclk_q;
    assign cs_n  = cs_n_q;
    assign busy  = (state_q != IDLE);
    assign data  = data_q;
    assign ch    = ch_q;
    assign valid = valid_q;

endmodule
